// File: rtl/brainhack_core.sv
// brainhack_core
// Two-state (FETCH/EXEC) interpreter for a Brainfuck-style language that uses
// 3-bit opcodes. Every instruction takes exactly two clocks. The core drives
// three external memories: a tape RAM, a loop-return stack RAM and a program
// ROM. Each memory read is combinational. Each RAM write happens on the
// rising clock edge while the matching enable is high.
//
// Ports:
//   clock          rising-edge system clock
//   reset_n        asynchronous active-low reset
//   i_tape_data    tape cell at o_tape_addr
//   i_prgmem_data  ROM opcode at o_prgmem_addr
//   i_stack_data   stack entry at o_stack_addr
//   o_tape_in      tape write enable (EXEC only)
//   o_tape_addr    tape pointer TP
//   o_tape_data    tape write data
//   o_prgmem_addr  program counter PC
//   o_stack_in     stack write enable (EXEC only)
//   o_stack_addr   SP, or SP+1 while a push is in progress
//   o_stack_data   stack write data (PC of the '[')
module brainhack_core #(
  parameter int TAPE_ADDR_W  = 8,
  parameter int TAPE_DATA_W  = 8,
  parameter int PRG_ADDR_W   = 8,
  parameter int STACK_ADDR_W = 4,
  parameter int INSTR_W      = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [TAPE_DATA_W-1:0]  i_tape_data,
  input  logic [INSTR_W-1:0]      i_prgmem_data,
  input  logic [PRG_ADDR_W-1:0]   i_stack_data,
  output logic                    o_tape_in,
  output logic [TAPE_ADDR_W-1:0]  o_tape_addr,
  output logic [TAPE_DATA_W-1:0]  o_tape_data,
  output logic [PRG_ADDR_W-1:0]   o_prgmem_addr,
  output logic                    o_stack_in,
  output logic [STACK_ADDR_W-1:0] o_stack_addr,
  output logic [PRG_ADDR_W-1:0]   o_stack_data
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [INSTR_W-1:0] OP_NOP  = 3'b000;
  localparam logic [INSTR_W-1:0] OP_INC_P = 3'b001;
  localparam logic [INSTR_W-1:0] OP_DEC_P = 3'b010;
  localparam logic [INSTR_W-1:0] OP_INC  = 3'b011;
  localparam logic [INSTR_W-1:0] OP_DEC  = 3'b100;
  localparam logic [INSTR_W-1:0] OP_HALT = 3'b101;
  localparam logic [INSTR_W-1:0] OP_OPEN = 3'b110;
  localparam logic [INSTR_W-1:0] OP_CLOSE = 3'b111;

  localparam logic [PRG_ADDR_W-1:0]   PC_ONE    = 1;
  localparam logic [TAPE_ADDR_W-1:0]  TP_ONE    = 1;
  localparam logic [TAPE_DATA_W-1:0]  DATA_ONE  = 1;
  localparam logic [STACK_ADDR_W-1:0] SP_ONE    = 1;
  localparam logic [STACK_ADDR_W:0]   DEPTH_ONE = 1;

  state_t                  state_reg, state_next;
  logic [PRG_ADDR_W-1:0]   pc_reg, pc_next;
  logic [TAPE_ADDR_W-1:0]  tp_reg, tp_next;
  logic [STACK_ADDR_W-1:0] sp_reg, sp_next;
  logic [INSTR_W-1:0]      ir_reg, ir_next;
  logic                    skip_reg, skip_next;
  // One bit wider than SP so a full stack's worth of nesting still fits.
  logic [STACK_ADDR_W:0]   depth_reg, depth_next;
  logic                    halted_reg, halted_next;
  logic                    zero;

  assign zero          = (i_tape_data == '0);
  assign o_tape_addr   = tp_reg;
  assign o_prgmem_addr = pc_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= FETCH;
      pc_reg     <= '0;
      tp_reg     <= '0;
      sp_reg     <= '0;
      ir_reg     <= '0;
      skip_reg   <= 1'b0;
      depth_reg  <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      tp_reg     <= tp_next;
      sp_reg     <= sp_next;
      ir_reg     <= ir_next;
      skip_reg   <= skip_next;
      depth_reg  <= depth_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    tp_next      = tp_reg;
    sp_next      = sp_reg;
    ir_next      = ir_reg;
    skip_next    = skip_reg;
    depth_next   = depth_reg;
    halted_next  = halted_reg;
    o_tape_in    = 1'b0;
    o_tape_data  = i_tape_data;
    o_stack_in   = 1'b0;
    o_stack_addr = sp_reg;
    o_stack_data = pc_reg;

    // Once halted, nothing moves until reset: the core never leaves FETCH.
    if (!halted_reg) begin
      case (state_reg)
        FETCH: begin
          ir_next    = i_prgmem_data;
          state_next = EXEC;
        end
        EXEC: begin
          state_next = FETCH;
          pc_next    = pc_reg + PC_ONE;
          if (skip_reg) begin
            // Scanning forward for the matching ']': only brackets count.
            if (ir_reg == OP_OPEN) begin
              depth_next = depth_reg + DEPTH_ONE;
            end else if (ir_reg == OP_CLOSE) begin
              depth_next = depth_reg - DEPTH_ONE;
              if (depth_reg == DEPTH_ONE) skip_next = 1'b0;
            end
          end else begin
            case (ir_reg)
              OP_NOP:   ;
              OP_INC_P: tp_next = tp_reg + TP_ONE;
              OP_DEC_P: tp_next = tp_reg - TP_ONE;
              OP_INC: begin
                o_tape_in   = 1'b1;
                o_tape_data = i_tape_data + DATA_ONE;
              end
              OP_DEC: begin
                o_tape_in   = 1'b1;
                o_tape_data = i_tape_data - DATA_ONE;
              end
              OP_HALT: begin
                halted_next = 1'b1;
                pc_next     = pc_reg;
              end
              OP_OPEN: begin
                if (zero) begin
                  skip_next  = 1'b1;
                  depth_next = DEPTH_ONE;
                end else begin
                  // Push the address of this '[' into the next free slot.
                  o_stack_in   = 1'b1;
                  o_stack_addr = sp_reg + SP_ONE;
                  sp_next      = sp_reg + SP_ONE;
                end
              end
              default: begin // OP_CLOSE
                if (zero) begin
                  sp_next = sp_reg - SP_ONE;
                end else begin
                  // Resume at the instruction right after the matching '['.
                  pc_next = i_stack_data + PC_ONE;
                end
              end
            endcase
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_brainhack_core.sv
module tb_brainhack_core;

  logic       clock;
  logic       reset_n;
  logic [7:0] i_tape_data;
  logic [2:0] i_prgmem_data;
  logic [7:0] i_stack_data;
  logic       o_tape_in;
  logic [7:0] o_tape_addr;
  logic [7:0] o_tape_data;
  logic [7:0] o_prgmem_addr;
  logic       o_stack_in;
  logic [3:0] o_stack_addr;
  logic [7:0] o_stack_data;

  logic [7:0] tape [256];
  logic [7:0] stack [16];
  logic [2:0] rom [256];
  logic       clr;
  int         tape_writes;
  int         stack_writes;
  int         n_checks;
  int         n_pass;

  brainhack_core dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_tape_data   (i_tape_data),
    .i_prgmem_data (i_prgmem_data),
    .i_stack_data  (i_stack_data),
    .o_tape_in     (o_tape_in),
    .o_tape_addr   (o_tape_addr),
    .o_tape_data   (o_tape_data),
    .o_prgmem_addr (o_prgmem_addr),
    .o_stack_in    (o_stack_in),
    .o_stack_addr  (o_stack_addr),
    .o_stack_data  (o_stack_data)
  );

  always #5 clock = ~clock;

  assign i_tape_data   = tape[o_tape_addr];
  assign i_stack_data  = stack[o_stack_addr];
  assign i_prgmem_data = rom[o_prgmem_addr];

  // Memory models; clr wipes tape to 0 and stack to a sentinel value.
  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= 8'h00;
      for (int i = 0; i < 16; i++) stack[i] <= 8'hAA;
      tape_writes  <= 0;
      stack_writes <= 0;
    end else begin
      if (o_tape_in) begin
        tape[o_tape_addr] <= o_tape_data;
        tape_writes <= tape_writes + 1;
      end
      if (o_stack_in) begin
        stack[o_stack_addr] <= o_stack_data;
        stack_writes <= stack_writes + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0d", tag, got);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 3'b000;
  endtask

  // Holds reset, wipes RAMs, then releases reset on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    clr     = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    clock    = 1'b0;
    reset_n  = 1'b0;
    clr      = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    clear_rom();

    // Skipped loop
    rom[1] = 3'b110; rom[2] = 3'b011; rom[3] = 3'b100; rom[4] = 3'b111;
    reset_n = 1'b0;
    clr     = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    check("rst_pc", o_prgmem_addr, 0);
    check("rst_tp", o_tape_addr, 0);
    check("rst_sp", o_stack_addr, 0);
    check("rst_tape_in", o_tape_in, 0);
    check("rst_stack_in", o_stack_in, 0);
    check("rst_skip", dut.skip_reg, 0);
    reset_n = 1'b1;
    cycles(4);
    check("skip_set_at_open", dut.skip_reg, 1);
    cycles(4);
    check("skip_held", dut.skip_reg, 1);
    cycles(2);
    check("skip_clr_at_close", dut.skip_reg, 0);
    check("skip_pc5", o_prgmem_addr, 5);
    check("skip_tape0", tape[0], 0);
    check("skip_sp", o_stack_addr, 0);
    check("skip_stack1", stack[1], 8'hAA);
    check("skip_tape_writes", tape_writes, 0);

    // Counted loop
    clear_rom();
    rom[0] = 3'b011; rom[1] = 3'b011; rom[2] = 3'b110;
    rom[3] = 3'b100; rom[4] = 3'b111; rom[5] = 3'b101;
    do_reset();
    cycles(6);
    check("loop_sp_after_push", o_stack_addr, 1);
    check("loop_stack1", stack[1], 2);
    cycles(24);
    check("loop_halt_pc", o_prgmem_addr, 5);
    check("loop_halted", dut.halted_reg, 1);
    check("loop_tape0", tape[0], 0);
    check("loop_sp_popped", o_stack_addr, 0);
    check("loop_tape_writes", tape_writes, 4);
    check("loop_stack_writes", stack_writes, 1);

    // Pointer and wrap
    clear_rom();
    rom[0] = 3'b010; rom[1] = 3'b100; rom[2] = 3'b101;
    do_reset();
    cycles(10);
    check("wrap_tp", o_tape_addr, 255);
    check("wrap_tape255", tape[255], 255);
    check("wrap_pc", o_prgmem_addr, 2);

    // Nested skip
    clear_rom();
    rom[0] = 3'b110; rom[1] = 3'b110; rom[2] = 3'b011; rom[3] = 3'b111;
    rom[4] = 3'b011; rom[5] = 3'b111; rom[6] = 3'b011; rom[7] = 3'b101;
    do_reset();
    cycles(2);
    check("nest_depth1", dut.depth_reg, 1);
    cycles(2);
    check("nest_depth2", dut.depth_reg, 2);
    cycles(4);
    check("nest_depth1b", dut.depth_reg, 1);
    cycles(4);
    check("nest_depth0", dut.depth_reg, 0);
    check("nest_skip_off", dut.skip_reg, 0);
    cycles(20);
    check("nest_tape0", tape[0], 1);
    check("nest_pc", o_prgmem_addr, 7);
    check("nest_tape_writes", tape_writes, 1);

    // Reset mid-run, during EXEC of the second '+'
    clear_rom();
    rom[0] = 3'b011; rom[1] = 3'b011; rom[2] = 3'b101;
    do_reset();
    cycles(3);
    check("mid_in_exec_we", o_tape_in, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_we_dropped", o_tape_in, 0);
    check("mid_pc_reset", o_prgmem_addr, 0);
    @(negedge clock);
    check("mid_tape0_kept", tape[0], 1);
    check("mid_no_write", tape_writes, 1);
    reset_n = 1'b1;
    cycles(10);
    check("mid_restart_tape0", tape[0], 3);
    check("mid_restart_pc", o_prgmem_addr, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brainhack_core.md
Name: brainhack_core

Overview:
- Multi-cycle interpreter for a Brainfuck-style language with 3-bit instructions.
- Drives three external memories: tape RAM (data cells), stack RAM (loop-return addresses) and program ROM.
- Memory models in the system:
  - RAM: combinational read, synchronous write on the rising clock edge when its write-enable is high.
  - ROM: combinational read.

Parameters:
- TAPE_ADDR_W, 8, tape address width (TP register width)
- TAPE_DATA_W, 8, tape cell width
- PRG_ADDR_W, 8, program address width (PC and stack entry width)
- STACK_ADDR_W, 4, stack address width (SP register width)
- INSTR_W, 3, instruction width (fixed at 3)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  active-low asynchronous reset
- i_tape_data  in  TAPE_DATA_W  tape read data at o_tape_addr
- i_prgmem_data  in  INSTR_W  ROM data at o_prgmem_addr
- i_stack_data  in  PRG_ADDR_W  stack read data at o_stack_addr
- o_tape_in  out  1  tape write enable
- o_tape_addr  out  TAPE_ADDR_W  equals TP
- o_tape_data  out  TAPE_DATA_W  tape write data
- o_prgmem_addr  out  PRG_ADDR_W  equals PC
- o_stack_in  out  1  stack write enable
- o_stack_addr  out  STACK_ADDR_W  stack address
- o_stack_data  out  PRG_ADDR_W  stack write data (PC)

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n).
- Reset values: PC=0, TP=0, SP=0, IR=000, skip=0, depth=0, halted=0, state=FETCH, o_tape_in=0, o_stack_in=0.
- Two-state FSM; every instruction takes exactly 2 cycles:
  - FETCH: IR<=i_prgmem_data; goes to EXEC.
  - EXEC: executes IR, updates PC, returns to FETCH.
  - Write enables are high only in EXEC.
- zero = (i_tape_data == 0), evaluated combinationally from tape[TP].
- Opcodes, normal mode (skip=0):
  - 000 NOP: PC+1.
  - 001 '>': TP+1 (wraps mod 2^TAPE_ADDR_W); PC+1.
  - 010 '<': TP-1 (wraps); PC+1.
  - 011 '+': o_tape_in=1, o_tape_data=i_tape_data+1 (wraps); PC+1.
  - 100 '-': o_tape_in=1, o_tape_data=i_tape_data-1 (wraps); PC+1.
  - 101 HALT: halted<=1; FSM freezes, PC holds, no further writes until reset.
  - 110 '[':
    - if !zero: push (o_stack_in=1, o_stack_addr=SP+1, o_stack_data=PC; SP<=SP+1), PC+1.
    - if zero: skip<=1, depth<=1, PC+1.
  - 111 ']':
    - if !zero: PC<=i_stack_data+1, with o_stack_addr=SP, i.e. jump to the instruction after the matching '['; SP unchanged.
    - if zero: SP<=SP-1 (pop), PC+1.
- Skip mode (skip=1): only bracket instructions act; no tape or stack writes; TP and SP are frozen; PC+1 every instruction.
  - '[': depth+1.
  - ']': depth-1; when depth reaches 0, skip<=0.
  - depth is STACK_ADDR_W+1 bits wide.
- Stack convention:
  - Top of stack is at address SP.
  - Address 0 is never written; the first push writes address 1.
  - Overflow and underflow wrap silently.
- o_stack_addr = SP except during a push in EXEC, when it is SP+1.
- PC wraps from 2^PRG_ADDR_W-1 to 0; unprogrammed ROM reads 000 (NOP).
- Reset mid-instruction aborts the instruction; a write in flight is suppressed because enables go low immediately.

Test Plan:
- Skipped loop:
  - Stimulus: tape[0]=0, ROM[0]=000, ROM[1..4]=110,011,100,111.
  - Response: skip asserts in EXEC of addr 1 and clears in EXEC of addr 4.
  - Response: tape[0] stays 0, SP stays 0, stack[1] never written, o_tape_in never high.
  - Response: PC reaches 5 after 10 cycles from reset release.
- Counted loop:
  - Stimulus: ROM 011,011,110,100,111,101.
  - Response: the push writes stack[1]=2 and SP=1; the loop body runs twice.
  - Response: tape[0]=0 and SP=0 after the final ']' pop; HALT freezes PC at 5.
- Pointer and wrap:
  - Stimulus: ROM 010,100,101 with tape zero.
  - Response: TP=255 and tape[255]=255; halt.
- Nested skip:
  - Stimulus: tape[0]=0, ROM 110,110,011,111,011,111,011,101.
  - Response: depth goes 1→2→1→0; only the final '+' executes, so tape[0]=1.
- Reset mid-run:
  - Stimulus: assert reset_n=0 asynchronously during EXEC of a '+'.
  - Response: all registers return to reset values at once; no tape write occurs; execution restarts from PC=0 after release.
